// File: rtl/des_op_sched.sv
`default_nettype none
// ==============================================================================
// des_op_sched: round-robin scheduler sharing one registered a/b/c->f datapath
// among N requesters; define SCHED_FIXED_PRIO_EN for lowest-index-wins. Rev 1.0
// ==============================================================================
module des_op_sched #(
  parameter  int W   = 12,
  parameter  int N   = 4,
  parameter  int LAT = 2,
  localparam int IW  = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  req_a,
  input  logic [N*W-1:0]  req_b,
  input  logic [N*W-1:0]  req_c,
  output logic [N-1:0]    gnt,
  output logic            dp_en,
  output logic [W-1:0]    dp_a,
  output logic [W-1:0]    dp_b,
  output logic [W-1:0]    dp_c,
  input  logic [W-1:0]    dp_f,
  output logic            rsp_valid,
  output logic [IW-1:0]   rsp_id,
  output logic [W-1:0]    rsp_data,
  input  logic            rsp_ready,
  output logic            busy
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            dp_en_q, dp_en_d;
  logic [W-1:0]    dp_a_q, dp_a_d;
  logic [W-1:0]    dp_b_q, dp_b_d;
  logic [W-1:0]    dp_c_q, dp_c_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic            busy_q, busy_d;

  logic [IW-1:0]   win;
  logic [W-1:0]    sel_a, sel_b, sel_c;

`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) win = IW'(i);
    end
  end
`else
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan downward so the requester closest to ptr (smallest offset) wins.
  always_comb begin
    int s;
    win = '0;
    s   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(ptr_q) + k;
      if (s >= N) s = s - N;
      if (req[IW'(s)]) win = IW'(s);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && |req) begin
      ptr_d = (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
        sel_c = req_c[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    dp_en_d     = 1'b0;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_c_d      = dp_c_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // Grant and issue strobe are registered here so they appear in ISSUE.
          gnt_d    = {{(N-1){1'b0}}, 1'b1} << win;
          dp_en_d  = 1'b1;
          dp_a_d   = sel_a;
          dp_b_d   = sel_b;
          dp_c_d   = sel_c;
          rsp_id_d = win;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d  = dp_f;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      dp_en_q     <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_c_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      dp_en_q     <= dp_en_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_c_q      <= dp_c_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign dp_en     = dp_en_q;
  assign dp_a      = dp_a_q;
  assign dp_b      = dp_b_q;
  assign dp_c      = dp_c_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_des_op_sched.sv
`default_nettype none
// tb_des_op_sched: directed + randomized checks of des_op_sched against a
// queue-free arbitration model and a keyed XOR datapath with LAT-cycle delay.
module tb_des_op_sched;
  localparam int W   = 12;
  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IW  = $clog2(N);
  localparam logic [W-1:0] KEY = 12'h943;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_a, req_b, req_c;
  logic [N-1:0]    gnt;
  logic            dp_en;
  logic [W-1:0]    dp_a, dp_b, dp_c, dp_f;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_ready;
  logic            busy;

  des_op_sched #(.W(W), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .gnt(gnt), .dp_en(dp_en), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_f(dp_f), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  logic [W-1:0] opc [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
      req_c[i*W +: W] = opc[i];
    end
  end

  // Datapath model: result becomes valid LAT clocks after the dp_en edge,
  // otherwise it shows a filler value.
  logic         tb_init;
  logic         pv [LAT];
  logic [W-1:0] pd [LAT];
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= dp_en;
      pd[0] <= dp_a ^ dp_b ^ dp_c ^ KEY;
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign dp_f = pv[LAT-1] ? pd[LAT-1] : 12'hEEE;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ptr_m    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 0; k < N; k++) if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
`endif
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},       32'(gnt),       32'd0);
    chk({tag, "_dp_en"},     32'(dp_en),     32'd0);
    chk({tag, "_dp_a"},      32'(dp_a),      32'd0);
    chk({tag, "_dp_b"},      32'(dp_b),      32'd0);
    chk({tag, "_dp_c"},      32'(dp_c),      32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // One complete service starting from an observed IDLE cycle; returns the
  // cycle in which gnt was seen. Leaves the DUT observed in IDLE.
  task automatic serve(input logic [N-1:0] r, input int stall, output int gcyc);
    int w, waited;
    logic [N-1:0] eg;
    logic [W-1:0] ea, eb, ec, ef;
    req       = r;
    rsp_ready = (stall == 0);
    w  = pick(r);
    ea = opa[w]; eb = opb[w]; ec = opc[w];
    ef = ea ^ eb ^ ec ^ KEY;
    eg = '0;
    eg[w] = 1'b1;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (gnt === '0 && waited < 20);
    gcyc = cyc;
    chk("gnt_latency", 32'(waited), 32'd1);
    chk("gnt",   32'(gnt),   32'(eg));
    chk("dp_en", 32'(dp_en), 32'd1);
    chk("dp_a",  32'(dp_a),  32'(ea));
    chk("dp_b",  32'(dp_b),  32'(eb));
    chk("dp_c",  32'(dp_c),  32'(ec));
    chk("busy_issue", 32'(busy), 32'd1);
    ptr_m = (w + 1) % N;
    opa[w] = W'($urandom);
    opb[w] = W'($urandom);
    opc[w] = W'($urandom);
    for (int k = 0; k < LAT; k++) begin
      tick();
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("wait_gnt",       32'(gnt),       32'd0);
      chk("wait_dp_en",     32'(dp_en),     32'd0);
    end
    tick();
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id",    32'(rsp_id),    32'(w));
    chk("rsp_data",  32'(rsp_data),  32'(ef));
    for (int k = 0; k < stall; k++) begin
      tick();
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_id",    32'(rsp_id),    32'(w));
      chk("stall_data",  32'(rsp_data),  32'(ef));
      chk("stall_gnt",   32'(gnt),       32'd0);
      chk("stall_dp_en", 32'(dp_en),     32'd0);
      chk("stall_busy",  32'(busy),      32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = (stall == 0);
    chk("idle_valid", 32'(rsp_valid), 32'd0);
    chk("idle_busy",  32'(busy),      32'd0);
    chk("idle_gnt",   32'(gnt),       32'd0);
  endtask

  initial begin
    int g0, g1, w;
    logic [N-1:0] eg;
    tb_init   = 1'b1;
    rst       = 1'b0;
    req       = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      opa[i] = W'($urandom);
      opb[i] = W'($urandom);
      opc[i] = W'($urandom);
    end
    repeat (3) tick();
    tb_init = 1'b0;
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Single requester with known operands: datapath yields 0xABC.
    opa[1] = 12'h00F; opb[1] = 12'h0F0; opc[1] = 12'h300;
    serve(4'b0010, 0, g0);
    chk("single_rsp_data", 32'(rsp_data), 32'h0ABC);
    chk("single_rsp_id",   32'(rsp_id),   32'd1);

    // Round-robin from ptr=2 back to ptr=0, then fairness with all requesting.
    serve(4'b0100, 0, g0);
    serve(4'b1000, 0, g0);
    serve(4'b1111, 0, g0);
    for (int k = 0; k < 4; k++) begin
      serve(4'b1111, 0, g1);
      chk("rr_spacing", 32'(g1 - g0), 32'(LAT + 3));
      g0 = g1;
    end

    // Backpressure with another requester waiting.
    serve(4'b1111, 10, g0);
    serve(4'b1111, 0, g1);
    chk("bp_spacing", 32'(g1 - g0), 32'(LAT + 3 + 10));

    // Reset during WAIT discards the op and clears ptr.
    req = 4'b1110;
    rsp_ready = 1'b0;
    w  = pick(req);
    eg = '0;
    eg[w] = 1'b1;
    tick();
    chk("abort_gnt", 32'(gnt), 32'(eg));
    tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("abort");
    rst = 1'b1;
    req = '0;
    ptr_m = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      chk("abort_no_rsp",  32'(rsp_valid), 32'd0);
      chk("abort_no_busy", 32'(busy),      32'd0);
    end
    serve(4'b1111, 0, g0);

    // Wrap with sparse requests: grant to 2 leaves ptr at 3.
    serve(4'b0100, 0, g0);
    serve(4'b1001, 0, g0);
    serve(4'b1001, 0, g0);
    serve(4'b1001, 0, g0);

    // Randomized requests and stalls.
    for (int k = 0; k < 10; k++) begin
      serve(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)), g0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_op_sched.md
# des_op_sched

Round-robin scheduler that shares one 12-bit operand datapath among N requesters. It accepts an (a, b, c) operand triple from the winning requester and issues it to the datapath with a one-cycle enable. It then waits the datapath's fixed latency, captures the result and returns it tagged with the requester index. It sits between the requester ports and the single registered a/b/c → f datapath instance.

## Interface
- W, 12: operand/result width.
- N, 4: number of requesters; N ≥ 2.
- LAT, 2: datapath latency in clocks from the dp_en edge to a valid dp_f; LAT ≥ 1.
- IW, $clog2(N): requester index width (localparam).
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset).
- req  in  N  per-requester request level; requester holds req and operands stable until its gnt.
- req_a, req_b, req_c  in  N*W each  flattened operands; requester i uses bits [i*W +: W].
- gnt  out  N  one-hot, one-cycle pulse; operands of that requester were accepted.
- dp_en  out  1  one-cycle issue strobe to the datapath.
- dp_a, dp_b, dp_c  out  W each  registered operands to the datapath; held until the next issue.
- dp_f  in  W  datapath result.
- rsp_valid  out  1  result available.
- rsp_id  out  IW  index of the requester that owns rsp_data.
- rsp_data  out  W  captured dp_f.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE. Encoding is free; all outputs are registered.
- IDLE: if any req bit is set, pick a winner by round-robin search starting at ptr, latch its operands into dp_a/b/c, record rsp_id, and go to ISSUE. ptr ← winner+1, wrapping at N−1 → 0. With no req, stay in IDLE.
- ISSUE (1 cycle): gnt[winner]=1, dp_en=1, cnt ← LAT−1. Next state is WAIT.
- WAIT: decrement cnt. When cnt==0, capture dp_f into rsp_data on that edge and go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_id hold stable until rsp_ready=1, then go to IDLE. There is no bypass: a request waiting during RESP is only arbitrated in the following IDLE cycle.
- A req deasserted before its grant is not serviced and produces no error.
- Reset values: gnt=0, dp_en=0, dp_a=dp_b=dp_c=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, ptr=0, cnt=0, state=IDLE.
- Reset mid-operation: the in-flight op is discarded, no response is produced, and any late dp_f is ignored.
- cnt width is $clog2(LAT+1). No arithmetic is performed on the data; W bits pass through unchanged.

## Timing
- Cycle t: IDLE with req sampled.
- Cycle t+1: gnt, dp_en and dp_a/b/c are valid.
- dp_f is captured at the edge ending cycle t+1+LAT.
- rsp_valid rises in cycle t+2+LAT. With LAT=2 that is cycle t+4.
- Minimum service period with rsp_ready held high is LAT+3 cycles per op (5 for LAT=2).
- Simultaneous events: rsp_ready in RESP with new req present → IDLE first, grant issued one cycle later. Multiple req bits → exactly one gnt per service.

## Configuration
- SCHED_FIXED_PRIO_EN defined: arbitration is fixed priority, lowest index wins. ptr is not implemented and has no effect.
- SCHED_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single requester: after reset, req=4'b0010 with a=0x00F, b=0x0F0, c=0x300, bench dp_f=0xABC at LAT. Required: gnt=0010 and dp_en at t+1, dp_a/b/c=0x00F/0x0F0/0x300; rsp_valid at t+4 with rsp_id=1, rsp_data=0xABC.
- Round-robin fairness: req=4'b1111 held, rsp_ready=1. Required: grant order 0,1,2,3,0 at 5-cycle spacing, with no back-to-back grants.
- Backpressure: rsp_ready=0 for 10 cycles during RESP. Required: rsp_valid, rsp_id and rsp_data stable; no gnt and no dp_en while stalled; next grant one cycle after IDLE is entered.
- Reset mid-op: assert rst=0 in a WAIT cycle. Required: the next cycle shows all outputs at reset values and ptr=0; no response is emitted for the aborted op.
- Wrap and sparse requests: req=4'b1001 with ptr=3 after a prior grant to 2. Required: grant to 3, then 0, then 3.
- SCHED_FIXED_PRIO_EN build: req=4'b1111 held. Required: every grant goes to requester 0.
